// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU tile fetch unit.
package npu_pkg;

    localparam int TILE_FETCH_BUF_DEPTH = 2;
    localparam int TILE_FETCH_WORD_W    = 32;

    typedef enum logic [1:0] {
        TF_IDLE  = 2'd0,
        TF_FETCH = 2'd1,
        TF_DRAIN = 2'd2,
        TF_FIN   = 2'd3
    } tile_fetch_state_e;

    typedef struct packed {
        logic [TILE_FETCH_WORD_W-1:0] data;
        logic                         last;
    } tile_fetch_entry_t;

endpackage

// File: rtl/npu_tile_fetch_buf.sv
// Two-entry FIFO holding fetched words (plus last flag) ahead of the output stream.
module npu_tile_fetch_buf
    import npu_pkg::*;
#(
    parameter int DATA_W = TILE_FETCH_WORD_W
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    tile_fetch_entry_t mem [TILE_FETCH_BUF_DEPTH];

    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (cnt == 2'(TILE_FETCH_BUF_DEPTH));
    assign empty   = (cnt == 2'd0);
    assign count   = cnt;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data-only; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr].data <= push_data;
            mem[wr_ptr].last <= push_last;
        end
    end

    assign head_data = mem[rd_ptr].data;
    assign head_last = mem[rd_ptr].last;

endmodule

// File: rtl/npu_tile_fetch.sv
// Tile fetch: walks a rows x cols word tile with a byte row stride, one outstanding LSU read.
// Optional stall counters enabled by defining NPU_TILE_FETCH_PERF_EN.
module npu_tile_fetch
    import npu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = TILE_FETCH_WORD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [ADDR_W-1:0] cfg_stride_i,
    input  logic [CNT_W-1:0]  cfg_rows_i,
    input  logic [CNT_W-1:0]  cfg_cols_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              m_r_valid_o,
    output logic [ADDR_W-1:0] m_r_addr_o,
    input  logic              m_r_ready_i,
    input  logic [DATA_W-1:0] m_r_data_i,
    output logic              m_rd_ready_o,
    output logic              o_valid_o,
    output logic [DATA_W-1:0] o_data_o,
    output logic              o_last_o,
    input  logic              o_ready_i
`ifdef NPU_TILE_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_req_stall_o,
    output logic [31:0]       perf_out_stall_o
`endif
);

    localparam int               WB        = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       BUF_DEPTH = 2'(TILE_FETCH_BUF_DEPTH);

    tile_fetch_state_e state, state_nxt;

    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] row_base;
    logic [CNT_W-1:0]  rows;
    logic [CNT_W-1:0]  cols;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic              req_vld;
    logic              done_q;

    logic              accept;
    logic              cfg_zero;
    logic              hs;
    logic              col_last;
    logic              last_word;
    logic              issue;
    logic              pop;
    logic              last_pop;

    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic [1:0]        buf_cnt;
    logic              buf_full;
    logic              buf_empty;

    assign accept    = (state == TF_IDLE) & start_i;
    assign cfg_zero  = (cfg_rows_i == '0) | (cfg_cols_i == '0);
    assign hs        = req_vld & m_r_ready_i;
    assign col_last  = (col == cols - CNT_ONE);
    assign last_word = col_last & (row == rows - CNT_ONE);
    // The in-flight request owns one buffer slot, so only issue into a free one.
    assign issue     = (state == TF_FETCH) & ~req_vld & (buf_cnt < BUF_DEPTH);
    assign pop       = ~buf_empty & o_ready_i;
    assign last_pop  = pop & head_last;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state <= TF_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b1;
        case (state)
            TF_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = cfg_zero ? TF_FIN : TF_FETCH;
            end
            TF_FETCH: if (hs && last_word) state_nxt = TF_DRAIN;
            TF_DRAIN: if (last_pop)        state_nxt = TF_FIN;
            TF_FIN:   state_nxt = TF_IDLE;
            default:  state_nxt = TF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            req_vld <= 1'b0;
            row     <= '0;
            col     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == TF_FIN);
            if (accept) begin
                row <= '0;
                col <= '0;
            end else if (hs) begin
                if (col_last) begin
                    col <= '0;
                    row <= row + CNT_ONE;
                end else begin
                    col <= col + CNT_ONE;
                end
            end
            if (hs)         req_vld <= 1'b0;
            else if (issue) req_vld <= 1'b1;
        end
    end

    // Latched tile geometry and running row address; only observed while busy.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            stride   <= cfg_stride_i;
            rows     <= cfg_rows_i;
            cols     <= cfg_cols_i;
            row_base <= cfg_base_i;
        end else if (hs && col_last) begin
            row_base <= row_base + stride;
        end
    end

    assign m_r_valid_o  = req_vld;
    assign m_rd_ready_o = req_vld;
    assign m_r_addr_o   = req_vld ? (row_base + ADDR_W'(col) * ADDR_W'(WB)) : '0;
    assign done_o       = done_q;

    npu_tile_fetch_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .push      (hs & ~buf_full),
        .push_data (m_r_data_i),
        .push_last (last_word),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .count     (buf_cnt),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign o_valid_o = ~buf_empty;
    assign o_data_o  = buf_empty ? '0 : head_data;
    assign o_last_o  = ~buf_empty & head_last;

`ifdef NPU_TILE_FETCH_PERF_EN
    logic [31:0] perf_req;
    logic [31:0] perf_out;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            perf_req <= '0;
            perf_out <= '0;
        end else if (accept) begin
            perf_req <= '0;
            perf_out <= '0;
        end else begin
            if (req_vld && !m_r_ready_i && !(&perf_req)) perf_req <= perf_req + 32'd1;
            if (o_valid_o && !o_ready_i && !(&perf_out)) perf_out <= perf_out + 32'd1;
        end
    end

    assign perf_req_stall_o = perf_req;
    assign perf_out_stall_o = perf_out;
`endif

endmodule

// File: doc/npu_tile_fetch.md
Name: npu_tile_fetch

Overview:
- Upstream request generator for npu_lsu: walks a 2-D tile (rows x cols words, byte row stride) and issues single-word reads on the LSU slave-side read channel.
- Returned words go into a 2-entry output buffer and leave on a valid/ready stream toward the compute datapath.
- Driven by the NPU controller through a start/done pulse pair with a latched configuration.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width; word byte size WB = DATA_W/8.
- CNT_W, 16, width of the row and column count fields.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1
- cfg_base_i  in  ADDR_W  tile base byte address
- cfg_stride_i  in  ADDR_W  byte distance between row starts
- cfg_rows_i  in  CNT_W  number of rows
- cfg_cols_i  in  CNT_W  words per row
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when the last word is accepted at the output
- m_r_valid_o  out  1  read request valid toward LSU
- m_r_addr_o  out  ADDR_W  read byte address
- m_r_ready_i  in  1  read completes this cycle; m_r_data_i valid
- m_r_data_i  in  DATA_W  read data
- m_rd_ready_o  out  1  data-accept ready toward LSU
- o_valid_o  out  1  output stream valid
- o_data_o  out  DATA_W  output word
- o_last_o  out  1  marks the final word of the tile
- o_ready_i  in  1  output stream ready

Behaviour:
- Reset: all outputs 0, FSM=IDLE, buffer empty, row/col counters 0.
- FSM states: IDLE, FETCH, DRAIN, FIN.
- IDLE: on start_i, latch cfg into internal registers and clear counters.
  - rows==0 or cols==0 goes to FIN with no requests.
  - Otherwise goes to FETCH; busy_o rises the next cycle.
- FETCH issue rule:
  - Issue a request only when at least one buffer entry is free. That entry is reserved for it.
  - m_r_valid_o=1 with m_r_addr_o = row_base + col*WB. row_base starts at base and adds stride per row. All arithmetic wraps modulo 2^ADDR_W.
  - While valid is high, m_rd_ready_o=1.
  - Once asserted, valid and addr stay stable until m_r_ready_i=1.
- Handshake: m_r_valid_o & m_r_ready_i writes m_r_data_i into the buffer in the same cycle, with o_last set if it is the final word.
  - The column counter then increments. On col==cols-1 the column wraps to 0, the row increments and row_base += stride.
  - After the final word's handshake, m_r_valid_o drops the next cycle and the FSM goes to DRAIN.
  - Single outstanding request; a new request may be issued the cycle after a handshake. Peak throughput: 1 word per 2 cycles.
- Output buffer: 2-entry FIFO.
  - o_valid_o = not empty; o_data_o/o_last_o come from the head entry.
  - Pop on o_valid_o & o_ready_i. Simultaneous push and pop when full is not possible because of the reservation.
  - Simultaneous push and pop otherwise keeps the count unchanged.
- DRAIN: on the pop of the o_last entry, go to FIN.
- FIN: done_o=1 for one cycle, busy_o drops the same cycle, return to IDLE.
- m_r_ready_i without m_r_valid_o is ignored.
- start_i in any state other than IDLE is ignored; cfg is not re-latched.
- Reset mid-operation: immediate return to IDLE, buffer flushed, no done_o. Any pending request is abandoned; the LSU is reset by the same arstn_i.

Optional Feature:
- Macro NPU_TILE_FETCH_PERF_EN.
- Defined: adds outputs perf_req_stall_o (32 bits) and perf_out_stall_o (32 bits).
  - perf_req_stall_o counts cycles with m_r_valid_o & ~m_r_ready_i.
  - perf_out_stall_o counts cycles with o_valid_o & ~o_ready_i.
  - Both clear on an accepted start and saturate at all-ones.
- Not defined: ports absent, no counter logic.

Decomposition:
- npu_pkg holds:
  - the FSM state enum tile_fetch_state_e;
  - the buffer-entry struct {data, last};
  - the constant TILE_FETCH_BUF_DEPTH=2.
- One sub-module: npu_tile_fetch_buf, the 2-entry FIFO with push/pop, count, full/empty.

Test Plan:
- Basic tile: base=0x100, stride=0x40, rows=2, cols=3, o_ready_i=1, m_r_ready_i one cycle after valid.
  - Expect addresses 0x100,0x104,0x108,0x140,0x144,0x148 in order.
  - o_last_o only on the 6th word; done_o exactly one pulse.
- Output backpressure: o_ready_i=0 after start, rows=1, cols=4.
  - After 2 handshakes m_r_valid_o stays 0.
  - Releasing o_ready_i resumes the 3rd request at 0x...08; all 4 words arrive in order.
- Zero size: rows=0, cols=5.
  - No m_r_valid_o; done_o pulses 2 cycles after start; busy_o high for 1 cycle.
- Address wrap: base=0xFFFF_FFF8, stride=0x10, rows=2, cols=2.
  - Expect 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0008, 0x0000_000C.
- Stall and restart: hold m_r_ready_i=0 for 5 cycles.
  - Addr stays stable; start_i pulsed mid-tile is ignored.
  - Assert arstn_i=0 mid-tile: all outputs 0 immediately; a new start then fetches the full tile correctly.
- Perf (with NPU_TILE_FETCH_PERF_EN): 5 request-stall cycles plus 3 output-stall cycles.
  - Counters read 5 and 3; they clear on the next start.
